enc_req_arbiter: RTL and testbench

//   Round-robin arbiter for four requesters sharing one downstream resource.
//   It produces a one-hot grant, an encoded 2-bit grant index and a valid flag,

---
 rtl/enc_req_arbiter.sv | 134 +++++++++++++
 tb/tb_enc_req_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/enc_req_arbiter.sv
// Round-robin arbiter for four requesters sharing one downstream resource.
// Emits a one-hot grant, a 2-bit encoded index and a valid flag so the grant
// can drive the shared datapath select directly. The owner keeps the grant
// until it drops its request.
// Optional feature macro: ARB_TIMEOUT_EN builds a hold counter that forces
// release after MAX_HOLD cycles and pulses timeout on that release.
module enc_req_arbiter #(
    parameter int unsigned MAX_HOLD = 15,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    output logic [3:0]       gnt,
    output logic [1:0]       gnt_idx,
    output logic             gnt_valid,
    output logic             timeout,
    output logic [CNT_W-1:0] grant_cnt
);

    typedef enum logic {StIdle, StOwn} state_e;

    state_e             state_q, state_d;
    logic [3:0]         gnt_q, gnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               win_found;
    logic [1:0]         win_idx;
    logic [1:0]         cand;
    logic               hold_expired;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("enc_req_arbiter: MAX_HOLD must be in 1..255");
    end

    // Pick the first active requester starting at ptr and wrapping 3->0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state logic: grant from IDLE, release from OWN on request drop or hold expiry.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d = StOwn;
                    gnt_d   = 4'b0001 << win_idx;
                    idx_d   = win_idx;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            StOwn: begin
                // Other request bits are ignored; only the owner's bit or the limit ends ownership.
                if (!req[idx_q] || hold_expired) begin
                    state_d = StIdle;
                    gnt_d   = 4'b0000;
                    idx_d   = 2'd0;
                    ptr_d   = idx_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gnt_q   <= 4'b0000;
            idx_q   <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;
    logic       timeout_q;

    // Counter equals MAX_HOLD-1 on the edge that ends the MAX_HOLD-th owned cycle.
    assign hold_expired = (state_q == StOwn) && (hold_q == 8'(MAX_HOLD - 1));

    // Hold counter: zero while idle so it starts from 0 on each new grant.
    always_comb begin
        hold_d = 8'd0;
        if (state_q == StOwn) begin
            hold_d = hold_q + 8'd1;
        end
    end

    // Timeout pulses only for a forced release; a simultaneous request drop wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= hold_expired && req[idx_q];
        end
    end

    assign timeout = timeout_q;
`else
    assign hold_expired = 1'b0;
    assign timeout      = 1'b0;
`endif

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = (state_q == StOwn);
    assign grant_cnt = cnt_q;

endmodule

// File: tb/tb_enc_req_arbiter.sv
// Directed bench for enc_req_arbiter; expected values are hand-derived.
// Works in both builds (ARB_TIMEOUT_EN defined or not), with MAX_HOLD=4.
module tb_enc_req_arbiter;

    localparam int unsigned MaxHold = 4;
    localparam int unsigned CntW    = 8;

    logic            clk;
    logic            rst_n;
    logic [3:0]      req;
    logic [3:0]      gnt;
    logic [1:0]      gnt_idx;
    logic            gnt_valid;
    logic            timeout;
    logic [CntW-1:0] grant_cnt;

    int n_checks;
    int n_fails;

    enc_req_arbiter #(
        .MAX_HOLD (MaxHold),
        .CNT_W    (CntW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout),
        .grant_cnt (grant_cnt)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string tag, input logic [3:0] g, input logic [1:0] i,
                               input logic v);
        check_eq({tag, ".gnt"}, 32'(gnt), 32'(g));
        check_eq({tag, ".idx"}, 32'(gnt_idx), 32'(i));
        check_eq({tag, ".valid"}, 32'(gnt_valid), 32'(v));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0000;
        #12;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        req      = 4'b0000;
        #12;
        // Reset state
        check_grant("rst", 4'b0000, 2'd0, 1'b0);
        check_eq("rst.timeout", 32'(timeout), 32'd0);
        check_eq("rst.cnt", 32'(grant_cnt), 32'd0);
        rst_n = 1'b1;

        // Test 1: single requester, one-cycle latency, release
        @(negedge clk);
        req = 4'b0001;
        tick();
        check_grant("t1.grant", 4'b0001, 2'd0, 1'b1);
        check_eq("t1.cnt", 32'(grant_cnt), 32'd1);
        req = 4'b0000;
        tick();
        check_grant("t1.release", 4'b0000, 2'd0, 1'b0);

        // Test 2: all requesting, round robin 0,1,2,3,0 with idle gaps
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            logic [1:0] e_idx;
            e_idx = 2'(k % 4);
            tick();
            check_grant($sformatf("t2.grant%0d", k), 4'b0001 << e_idx, e_idx, 1'b1);
            tick();
            tick();
            req[e_idx] = 1'b0;
            tick();
            check_eq($sformatf("t2.gap%0d", k), 32'(gnt_valid), 32'd0);
            req = 4'b1111;
        end
        check_eq("t2.cnt", 32'(grant_cnt), 32'd5);
        // ptr=1 now; park idle
        req = 4'b0000;
        tick();

        // Test 3: grant idx 2, release (ptr=3), then 0011 wraps to idx 0
        req = 4'b0100;
        tick();
        check_grant("t3.own2", 4'b0100, 2'd2, 1'b1);
        req = 4'b0000;
        tick();
        req = 4'b0011;
        tick();
        check_grant("t3.wrap", 4'b0001, 2'd0, 1'b1);
        req = 4'b0000;
        tick();

        // Test 4: owner idx1 ignores req[0] toggles; after drop, idle then idx0
        req = 4'b0011;
        tick();
        check_grant("t4.own1", 4'b0010, 2'd1, 1'b1);
        req = 4'b0010;
        tick();
        check_eq("t4.hold_a", 32'(gnt), 32'b0010);
        req = 4'b0011;
        tick();
        check_eq("t4.hold_b", 32'(gnt), 32'b0010);
        req = 4'b0001;
        tick();
        check_grant("t4.idle", 4'b0000, 2'd0, 1'b0);
        tick();
        check_grant("t4.next", 4'b0001, 2'd0, 1'b1);
        check_eq("t4.cnt", 32'(grant_cnt), 32'd9);

        // Test 5: hold limit
        do_reset();
        req = 4'b0101;
        tick();
        check_grant("t5.grant", 4'b0001, 2'd0, 1'b1);
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k < int'(MaxHold); k++) begin
            tick();
            check_eq($sformatf("t5.held%0d", k), 32'(gnt_valid), 32'd1);
            check_eq($sformatf("t5.to%0d", k), 32'(timeout), 32'd0);
        end
        tick();
        check_grant("t5.forced", 4'b0000, 2'd0, 1'b0);
        check_eq("t5.pulse", 32'(timeout), 32'd1);
        tick();
        check_grant("t5.next", 4'b0100, 2'd2, 1'b1);
        check_eq("t5.pulse_end", 32'(timeout), 32'd0);
`else
        for (int k = 1; k <= 10; k++) begin
            tick();
            check_eq($sformatf("t5.held%0d", k), 32'(gnt), 32'b0001);
            check_eq($sformatf("t5.to%0d", k), 32'(timeout), 32'd0);
        end
`endif

        // Test 6: asynchronous reset mid-grant, then grant idx 3
        req = 4'b1000;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_grant("t6.async", 4'b0000, 2'd0, 1'b0);
        check_eq("t6.async_cnt", 32'(grant_cnt), 32'd0);
        check_eq("t6.async_to", 32'(timeout), 32'd0);
        #3;
        rst_n = 1'b1;
        tick();
        check_grant("t6.grant3", 4'b1000, 2'd3, 1'b1);
        check_eq("t6.cnt", 32'(grant_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
